// File: rtl/pe_pkg.sv
// Purpose: shared constants and state encoding for the PE sequencer slice.
// Contents: default widths, tap count, PE counter codes, FSM state enum.
package pe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned LEN_W_DEF      = 10;
  localparam int unsigned TAPS           = 5;
  localparam int unsigned CNT_W          = 3;

  // Counter code that tells the PE nothing is happening this cycle.
  localparam logic [CNT_W-1:0] CNT_IDLE  = 3'd7;
  // Counter code that shifts the PE IA window (and writes the last tap).
  localparam logic [CNT_W-1:0] CNT_SHIFT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_FILL    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } pe_state_e;

endpackage

// File: rtl/pe_sequencer_if.sv
// Purpose: bundles the config, global-buffer and PE-side signals of the sequencer.
// Modports: master = sequencer view (drives *_out), slave = environment view.
interface pe_sequencer_if #(
  parameter int unsigned DATA_WIDTH = pe_pkg::DATA_WIDTH_DEF,
  parameter int unsigned LEN_W      = pe_pkg::LEN_W_DEF
);

  logic                  cfg_start_in;
  logic [LEN_W-1:0]      cfg_num_samples_in;
  logic                  flt_valid_in;
  logic [DATA_WIDTH-1:0] flt_data_in;
  logic                  flt_ready_out;
  logic                  ia_valid_in;
  logic [DATA_WIDTH-1:0] ia_data_in;
  logic                  ia_ready_out;
  logic                  pe_start_out;
  logic [2:0]            pe_counter_out;
  logic [2:0]            pe_state_out;
  logic                  pe_ia_valid_out;
  logic [DATA_WIDTH-1:0] pe_ia_out;
  logic                  pe_flt_valid_out;
  logic [DATA_WIDTH-1:0] pe_flt_out;
  logic                  pe_valid_in;
  logic                  busy_out;
  logic                  done_out;
  logic                  err_out;

  modport master (
    input  cfg_start_in, cfg_num_samples_in,
    input  flt_valid_in, flt_data_in, ia_valid_in, ia_data_in, pe_valid_in,
    output flt_ready_out, ia_ready_out,
    output pe_start_out, pe_counter_out, pe_state_out,
    output pe_ia_valid_out, pe_ia_out, pe_flt_valid_out, pe_flt_out,
    output busy_out, done_out, err_out
  );

  modport slave (
    output cfg_start_in, cfg_num_samples_in,
    output flt_valid_in, flt_data_in, ia_valid_in, ia_data_in, pe_valid_in,
    input  flt_ready_out, ia_ready_out,
    input  pe_start_out, pe_counter_out, pe_state_out,
    input  pe_ia_valid_out, pe_ia_out, pe_flt_valid_out, pe_flt_out,
    input  busy_out, done_out, err_out
  );

endinterface

// File: rtl/pe_window_counter.sv
// Purpose: registered PE CTRL counter; idles at 7, starts at 0, steps up to 4, or loads a value.
// Ports: clk, rst (sync, active-high); idle_i/start_i/load_i/step_i commands (priority in that
//        order), load_val_i; cnt_o current code, pre_shift_o (next step reaches 4), at_shift_o.
module pe_window_counter
  import pe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             idle_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             pre_shift_o,
  output logic             at_shift_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next counter value; a step never moves past the shift code.
  always_comb begin
    cnt_d = cnt_q;
    if (idle_i) begin
      cnt_d = CNT_IDLE;
    end else if (start_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (step_i && (cnt_q != CNT_SHIFT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= CNT_IDLE;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o       = cnt_q;
  assign pre_shift_o = (cnt_q == CNT_SHIFT - CNT_W'(1));
  assign at_shift_o  = (cnt_q == CNT_SHIFT);

endmodule

// File: rtl/pe_sequencer.sv
// Purpose: sequences one PE through a 1-D convolution pass: load 5 taps, prime the 5-deep
//          IA window, then run one 5-cycle MAC window per output and count PE results.
// Ports: clk, rst (sync, active-high); bus (pe_sequencer_if.master) carrying config, the
//        tap/IA valid-ready sources, PE command outputs, PE result pulse and status.
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pe_sequencer_if.master  bus
);

  pe_state_e             state_q;
  logic [LEN_W-1:0]      n_q, t_q, w_q, r_q;
  logic                  win_act_q;
  logic                  flt_ready_q, ia_ready_q, pe_start_q;
  logic                  pe_ia_valid_q, pe_flt_valid_q;
  logic [DATA_WIDTH-1:0] pe_ia_q, pe_flt_q;
  logic                  busy_q, done_q, err_q;

  logic [LEN_W-1:0]      n_m5, n_m4;
  logic [CNT_W-1:0]      cnt, wc_val_c;
  logic                  pre_shift, at_shift;
  logic                  tap_take_c, ia_fill_c, resume_c, final_win_c;
  logic                  win_start_c, win_step_c, win_end_c, pop_c;
  logic                  wc_idle_c, wc_load_c;

  assign n_m5        = n_q - LEN_W'(TAPS);
  assign n_m4        = n_q - LEN_W'(TAPS - 1);
  assign final_win_c = (w_q == n_m5);

  // Per-cycle decisions shared by the FSM register and the PE counter.
  always_comb begin
    tap_take_c  = (state_q == ST_LOAD_W) && bus.flt_valid_in;
    ia_fill_c   = (state_q == ST_FILL) && bus.ia_valid_in;
    // WAIT only resumes when the counter-4 pop is guaranteed a sample.
    resume_c    = (state_q == ST_WAIT) && (bus.ia_valid_in || final_win_c);
    // win_act_q low in COMPUTE means we just left FILL: the counter still shows the last shift.
    win_start_c = ((state_q == ST_COMPUTE) && !win_act_q) || resume_c;
    win_step_c  = (state_q == ST_COMPUTE) && win_act_q && !at_shift;
    win_end_c   = (state_q == ST_COMPUTE) && win_act_q && at_shift;
    pop_c       = win_step_c && pre_shift && !final_win_c;
    wc_load_c   = tap_take_c || ia_fill_c;
    wc_idle_c   = !(wc_load_c || win_start_c || win_step_c);
    wc_val_c    = tap_take_c ? t_q[CNT_W-1:0] : CNT_SHIFT;
  end

  pe_window_counter u_wcnt (
    .clk         (clk),
    .rst         (rst),
    .idle_i      (wc_idle_c),
    .start_i     (win_start_c),
    .load_i      (wc_load_c),
    .step_i      (win_step_c),
    .load_val_i  (wc_val_c),
    .cnt_o       (cnt),
    .pre_shift_o (pre_shift),
    .at_shift_o  (at_shift)
  );

  // Pass FSM with registered PE commands, handshakes and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      t_q            <= '0;
      w_q            <= '0;
      r_q            <= '0;
      win_act_q      <= 1'b0;
      flt_ready_q    <= 1'b0;
      ia_ready_q     <= 1'b0;
      pe_start_q     <= 1'b0;
      pe_ia_valid_q  <= 1'b0;
      pe_flt_valid_q <= 1'b0;
      pe_ia_q        <= '0;
      pe_flt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      flt_ready_q    <= 1'b0;
      ia_ready_q     <= 1'b0;
      pe_start_q     <= 1'b0;
      pe_ia_valid_q  <= 1'b0;
      pe_flt_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;

      // Result count saturates at the expected number of outputs.
      if ((state_q != ST_IDLE) && bus.pe_valid_in && (r_q != n_m4)) begin
        r_q <= r_q + LEN_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_start_in) begin
            n_q       <= bus.cfg_num_samples_in;
            t_q       <= '0;
            w_q       <= '0;
            r_q       <= '0;
            win_act_q <= 1'b0;
            busy_q    <= 1'b1;
            if (bus.cfg_num_samples_in < LEN_W'(TAPS)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_LOAD_W;
            end
          end
        end

        ST_LOAD_W: begin
          if (tap_take_c) begin
            flt_ready_q    <= 1'b1;
            pe_start_q     <= 1'b1;
            pe_flt_valid_q <= 1'b1;
            pe_flt_q       <= bus.flt_data_in;
            if (t_q == LEN_W'(TAPS - 1)) begin
              t_q     <= '0;
              state_q <= ST_FILL;
            end else begin
              t_q <= t_q + LEN_W'(1);
            end
          end
        end

        ST_FILL: begin
          if (ia_fill_c) begin
            ia_ready_q    <= 1'b1;
            pe_ia_valid_q <= 1'b1;
            pe_ia_q       <= bus.ia_data_in;
            if (t_q == LEN_W'(TAPS - 1)) begin
              t_q       <= '0;
              w_q       <= '0;
              win_act_q <= 1'b0;
              state_q   <= ST_COMPUTE;
            end else begin
              t_q <= t_q + LEN_W'(1);
            end
          end
        end

        ST_COMPUTE: begin
          if (win_start_c) win_act_q <= 1'b1;
          // The counter-4 command carries the next IA sample, except in the final window.
          if (pop_c) begin
            ia_ready_q    <= 1'b1;
            pe_ia_valid_q <= 1'b1;
            pe_ia_q       <= bus.ia_data_in;
          end
          if (win_end_c) begin
            win_act_q <= 1'b0;
            w_q       <= w_q + LEN_W'(1);
            state_q   <= ((w_q + LEN_W'(1)) == n_m4) ? ST_DRAIN : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (resume_c) begin
            win_act_q <= 1'b1;
            state_q   <= ST_COMPUTE;
          end
        end

        ST_DRAIN: begin
          if (r_q == n_m4) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.flt_ready_out    = flt_ready_q;
  assign bus.ia_ready_out     = ia_ready_q;
  assign bus.pe_start_out     = pe_start_q;
  assign bus.pe_counter_out   = cnt;
  assign bus.pe_state_out     = state_q;
  assign bus.pe_ia_valid_out  = pe_ia_valid_q;
  assign bus.pe_ia_out        = pe_ia_q;
  assign bus.pe_flt_valid_out = pe_flt_valid_q;
  assign bus.pe_flt_out       = pe_flt_q;
  assign bus.busy_out         = busy_q;
  assign bus.done_out         = done_q;
  assign bus.err_out          = err_q;

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
- Controller that sequences one PE through a full 1-D convolution pass.
- Phase 1 loads 5 filter taps. Phase 2 primes the 5-deep IA window. Phase 3 runs one 5-cycle MAC window per output sample.
- Sits between the global buffer (valid/ready sources for taps and IA samples) and the PE. It drives the PE's start, CTRL_counter and current_state inputs and counts PE results until the pass is done.

Parameters:
- DATA_WIDTH, 16, width of IA and filter samples forwarded to the PE.
- LEN_W, 10, width of cfg_num_samples; a pass is at most 2^LEN_W-1 IA samples.
- TAPS, 5, filter taps and IA window depth; fixed at 5 because the PE buffers are 5 deep.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start_in  in  1  one-cycle pulse; starts a pass (ignored unless IDLE).
- cfg_num_samples_in  in  LEN_W  IA samples in the pass; sampled on cfg_start_in.
- flt_valid_in  in  1  global-buffer tap valid.
- flt_data_in  in  DATA_WIDTH  tap value.
- flt_ready_out  out  1  tap consumed this cycle.
- ia_valid_in  in  1  global-buffer IA valid.
- ia_data_in  in  DATA_WIDTH  IA sample.
- ia_ready_out  out  1  IA sample consumed this cycle.
- pe_start_out  out  1  to PE start_in; a tap write at index pe_counter_out.
- pe_counter_out  out  3  to PE CTRL_counter_in. Values 0..4 are active; 7 is the idle code.
- pe_state_out  out  3  to PE current_state_in; current FSM encoding.
- pe_ia_valid_out / pe_ia_out  out  1 / DATA_WIDTH  to PE IA_valid_in / IA_in.
- pe_flt_valid_out / pe_flt_out  out  1 / DATA_WIDTH  to PE Filter_valid_in / Filter_in.
- pe_valid_in  in  1  PE_valid_out; one pulse per finished output.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse at end of pass.
- err_out  out  1  one-cycle pulse with done_out when the pass was rejected.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - pe_counter_out=7.
  - All valids, readys, pe_start_out, busy_out, done_out and err_out are 0.
  - Data outputs are 0.
  - Internal counters are 0.
- State encoding (pe_state_out): IDLE=0, LOAD_W=1, FILL=2, WAIT=3, COMPUTE=4, DRAIN=5, DONE=6.
- All outputs are registered; the PE sees each command one cycle after the FSM decision.
- IDLE:
  - On cfg_start_in, latch N=cfg_num_samples_in.
  - If N<5, go to DONE with err.
  - Otherwise go to LOAD_W with tap index t=0.
- LOAD_W: on each cycle with flt_valid_in:
  - Pulse flt_ready_out.
  - Drive pe_start_out=1, pe_counter_out=t, pe_flt_out=flt_data_in, pe_flt_valid_out=1.
  - Increment t. After t=4 is written, go to FILL.
  - Cycles without flt_valid_in drive pe_start_out=0 and pe_counter_out=7 (no PE write).
- FILL: on each cycle with ia_valid_in:
  - Pulse ia_ready_out.
  - Drive pe_counter_out=4, pe_ia_out=ia_data_in, pe_ia_valid_out=1 (this shifts the PE window).
  - After 5 samples, go to COMPUTE with window index w=0.
  - Cycles without ia_valid_in drive pe_counter_out=7.
- COMPUTE:
  - pe_counter_out steps 0,1,2,3,4 on consecutive cycles; pe_start_out=0 throughout.
  - At counter 4 of a non-final window, the pending IA sample is popped (ia_ready_out=1) and forwarded with pe_ia_valid_out=1.
  - At counter 4 of the final window (w=N-5), nothing is popped and pe_ia_valid_out=0.
  - After counter 4: increment w. If w=N-4, go to DRAIN. Else go to WAIT.
- WAIT:
  - pe_counter_out=7.
  - Return to COMPUTE at counter 0 only when ia_valid_in=1, or immediately if the next window is the final one.
  - This guarantees the counter-4 pop never stalls. The counter is never held at 4, because holding at 4 would re-shift the PE window.
  - A valid sample must stay stable until ready; this is the global-buffer rule.
- pe_valid_in:
  - Increments the output count r in every state except IDLE.
  - DRAIN waits for r=N-4, then goes to DONE.
  - Pulses after r reaches N-4 are ignored.
- DONE: one cycle. done_out=1; err_out=1 if the pass was rejected. Then go to IDLE.
- cfg_start_in while busy_out=1 is ignored and does not alter N.
- rst asserted mid-pass aborts the pass on the next edge, with no done_out pulse. The PE's own tap and IA memories are not cleared by this block.
- Counters t, w and r are LEN_W bits wide and never wrap, since N≤2^LEN_W-1.

Decomposition:
- Shared package (pe_pkg):
  - State encodings.
  - TAPS=5.
  - CNT_IDLE=3'd7.
  - CNT_SHIFT=3'd4 (counter value that shifts the PE IA window).
- One natural sub-module: pe_window_counter. It holds the 0..4 cycle counter with start/advance/idle-code outputs and is reused by any future multi-PE scheduler.

Test Plan:
- N=8, taps 1..5, IA 10..17, always valid:
  - 5 tap writes at counters 0..4, then 5 FILL shifts.
  - 4 windows with 3 pops; the final window pops nothing.
  - done_out follows the 4th pe_valid_in. Total IA pops=8.
- Same stimulus, flt_valid_in low on alternate cycles:
  - pe_counter_out=7 and pe_start_out=0 on idle cycles.
  - Taps still land at indices 0..4 in order.
- N=7, ia_valid_in withheld 6 cycles after the first window:
  - FSM sits in WAIT with counter 7, and counter never shows 4 while waiting.
  - Resumes at counter 0 the cycle after valid rises.
- N=4 -> DONE next cycle with done_out=1 and err_out=1; no ready pulses.
- cfg_start_in pulsed mid-COMPUTE with N'=20 -> ignored; pass finishes with the original N.
- rst high during COMPUTE w=2 -> next cycle IDLE, counter 7, busy_out=0, no done_out pulse. A new pass then completes normally.
